uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536, max cycles from start pulse to tx_done before abort (>=2).
REQ-003 SHALL have parameter CFG_DEFAULT, default 5'b00011, cfg_reg_out reset value (8-N-1).
REQ-004 SHALL have a single clock and a synchronous, active-high reset, with the ports below in the order given.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid_in  input  NUM_REQ  requester i has a byte pending.
REQ-008 req_data_in  input  8*NUM_REQ  requester i byte at [8i+7:8i].
REQ-009 req_cfg_in  input  5*NUM_REQ  requester i frame config at [5i+4:5i].
REQ-010 req_ready_out  output  NUM_REQ  one-hot accept strobe.
REQ-011 tx_data_out  output  8  byte to uart_top tx_data_in.
REQ-012 cfg_reg_out  output  5  to uart_top cfg_reg_in.
REQ-013 start_tx_out  output  1  to uart_top start_tx_in.
REQ-014 tx_busy_in  input  1  from uart_top tx_busy_out.
REQ-015 tx_done_in  input  1  from uart_top tx_done_out.
REQ-016 cts_n_in  input  1  remote clear-to-send, active low.
REQ-017 grant_id_out  output  $clog2(NUM_REQ)  index of current/last granted requester.
REQ-018 active_out  output  1  high in START and WAIT_DONE.
REQ-019 timeout_err_out  output  1  one-cycle pulse on frame abort.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT_DONE.
REQ-021 IDLE: grant when |req_valid_in & !cts_n_in & !tx_busy_in; else stay.
REQ-022 Winner = first valid index searching from (last_grant+1) mod NUM_REQ upward with wrap (round robin).
REQ-023 On grant: req_ready_out[winner]=1 combinationally that cycle only; data/cfg of winner registered into tx_data_out/cfg_reg_out, grant_id_out=winner, next state START.
REQ-024 Transfer accepted iff req_valid_in[i] & req_ready_out[i] same cycle; requesters hold valid/data stable until accepted.
REQ-025 START: start_tx_out=1 for exactly one cycle, timer cleared, next state WAIT_DONE.
REQ-026 WAIT_DONE: timer +1 per cycle; tx_done_in=1 -> IDLE, last_grant=grant_id_out.
REQ-027 Timer reaching TIMEOUT_CYCLES-1 without tx_done_in -> timeout_err_out pulse 1 cycle, IDLE, last_grant updated.
REQ-028 tx_done_in and timeout same cycle: done wins, no error pulse.
REQ-029 tx_data_out, cfg_reg_out SHALL stay constant from grant until return to IDLE and after, until next grant.
REQ-030 tx_done_in in IDLE/START SHALL be ignored.
REQ-031 cts_n_in or req_valid_in changes during START/WAIT_DONE SHALL NOT affect the current frame.
REQ-032 Minimum spacing: tx_done_in at cycle t -> earliest next req_ready_out at t+1, start_tx_out at t+2.
REQ-033 req_ready_out SHALL be zero outside IDLE and never multi-hot.
REQ-034 Timer width $clog2(TIMEOUT_CYCLES); SHALL NOT wrap.

Reset
REQ-035 rst=1 SHALL, at next edge, force IDLE, timer 0, last_grant NUM_REQ-1 (requester 0 first priority).
REQ-036 Reset values: req_ready_out 0, start_tx_out 0, tx_data_out 8'h00, cfg_reg_out CFG_DEFAULT, grant_id_out 0, active_out 0, timeout_err_out 0.
REQ-037 Reset mid-frame SHALL abort silently (no error pulse); un-accepted requests remain pending at requester.

Verification
REQ-038 Req1 valid 0x55, cfg 00011, cts_n 0, busy 0 -> req_ready_out=0010 one cycle, next cycle start_tx_out=1, tx_data_out 0x55, cfg 00011, grant_id 1.
REQ-039 All four valid continuously, tx_done 10 cycles after each start -> grant order 0,1,2,3,0,1; no gaps below REQ-032.
REQ-040 cts_n_in=1 with req2 valid -> no ready for 50 cycles; cts_n_in->0 -> req_ready_out=0100 same cycle.
REQ-041 TIMEOUT_CYCLES=64, tx_done never asserted -> timeout_err_out pulse 64 cycles after start_tx_out, next grant goes to following requester.
REQ-042 rst pulsed in WAIT_DONE -> reset values next cycle, no error pulse; with req0 and req3 valid, req0 granted first.
REQ-043 Loopback with uart_top (txd->rxd): req0 sends 0xA5, req1 sends 0x3C -> rx_data_out 0xA5 then 0x3C, parity_error_out 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that feeds bytes from NUM_REQ requesters into a single
//   UART transmitter. A byte is granted only when the remote end is clear to
//   send and the transmitter is idle. The byte and frame config are latched,
//   a one-cycle start pulse is issued, and the arbiter waits for tx_done_in.
//   A frame that never completes is aborted after TIMEOUT_CYCLES.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid_in      per-requester byte pending
//   req_data_in       requester i byte at [8i+7:8i]
//   req_cfg_in        requester i frame config at [5i+4:5i]
//   req_ready_out     one-hot accept strobe (combinational, IDLE only)
//   tx_data_out       latched byte to the transmitter
//   cfg_reg_out       latched frame config to the transmitter
//   start_tx_out      one-cycle start pulse
//   tx_busy_in        transmitter busy
//   tx_done_in        transmitter finished the frame
//   cts_n_in          remote clear-to-send, active low
//   grant_id_out      index of current/last granted requester
//   active_out        high while a frame is in flight
//   timeout_err_out   one-cycle pulse when a frame is aborted
module uart_tx_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          TIMEOUT_CYCLES = 65536,
  parameter logic [4:0]  CFG_DEFAULT    = 5'b00011
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [8*NUM_REQ-1:0]       req_data_in,
  input  logic [5*NUM_REQ-1:0]       req_cfg_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic [7:0]                 tx_data_out,
  output logic [4:0]                 cfg_reg_out,
  output logic                       start_tx_out,
  input  logic                       tx_busy_in,
  input  logic                       tx_done_in,
  input  logic                       cts_n_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  output logic                       active_out,
  output logic                       timeout_err_out
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [GW-1:0] last_grant;

  logic [7:0]    data_arr [NUM_REQ];
  logic [4:0]    cfg_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data_in[8*i +: 8];
    assign cfg_arr[i]  = req_cfg_in[5*i +: 5];
  end

  // Round-robin search starting one past the last served requester.
  // The sum never exceeds 2*NUM_REQ-1, so one conditional subtract wraps it.
  logic [GW:0]   rr_sum;
  logic [GW-1:0] win_idx;
  logic          win_found;

  always_comb begin
    rr_sum    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(NUM_REQ))
        rr_sum = rr_sum - (GW+1)'(NUM_REQ);
      if (!win_found && req_valid_in[rr_sum[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[GW-1:0];
      end
    end
  end

  logic grant;
  assign grant = (state == IDLE) && win_found && !cts_n_in && !tx_busy_in;

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  assign req_ready_out = grant ? (NUM_REQ'(1) << win_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      last_grant      <= GW'(NUM_REQ-1);
      start_tx_out    <= 1'b0;
      tx_data_out     <= 8'h00;
      cfg_reg_out     <= CFG_DEFAULT;
      grant_id_out    <= '0;
      active_out      <= 1'b0;
      timeout_err_out <= 1'b0;
    end else begin
      start_tx_out    <= 1'b0;
      timeout_err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data_out  <= data_arr[win_idx];
            cfg_reg_out  <= cfg_arr[win_idx];
            grant_id_out <= win_idx;
            start_tx_out <= 1'b1;
            active_out   <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (tx_done_in) begin
            state      <= IDLE;
            active_out <= 1'b0;
            last_grant <= grant_id_out;
          end else if (timer == TW'(TIMEOUT_CYCLES-2)) begin
            // Timer is about to reach TIMEOUT_CYCLES-1: abort the frame.
            timeout_err_out <= 1'b1;
            state           <= IDLE;
            active_out      <= 1'b0;
            last_grant      <= grant_id_out;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid_in;
  logic [8*NUM_REQ-1:0] req_data_in;
  logic [5*NUM_REQ-1:0] req_cfg_in;
  logic [NUM_REQ-1:0]   req_ready_out;
  logic [7:0]           tx_data_out;
  logic [4:0]           cfg_reg_out;
  logic                 start_tx_out;
  logic                 tx_busy_in;
  logic                 tx_done_in;
  logic                 cts_n_in;
  logic [1:0]           grant_id_out;
  logic                 active_out;
  logic                 timeout_err_out;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO), .CFG_DEFAULT(5'b00011)) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_cfg_in(req_cfg_in),
    .req_ready_out(req_ready_out), .tx_data_out(tx_data_out), .cfg_reg_out(cfg_reg_out),
    .start_tx_out(start_tx_out), .tx_busy_in(tx_busy_in), .tx_done_in(tx_done_in),
    .cts_n_in(cts_n_in), .grant_id_out(grant_id_out), .active_out(active_out),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data_in[8*i +: 8] = 8'hA0 + 8'(i);
      req_cfg_in[5*i +: 5]  = 5'(i + 8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready_out !== 4'b0 || start_tx_out !== 1'b0 || tx_data_out !== 8'h00 ||
        cfg_reg_out !== 5'b00011 || grant_id_out !== 2'd0 || active_out !== 1'b0 ||
        timeout_err_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b st=%b d=%h cfg=%b gid=%0d act=%b to=%b required 0 0 00 00011 0 0 0",
               req_ready_out, start_tx_out, tx_data_out, cfg_reg_out, grant_id_out, active_out, timeout_err_out);
    end
  endtask

  task automatic test_single();
    req_data_in[15:8] = 8'h55;
    req_cfg_in[9:5]   = 5'b00011;
    req_valid_in      = 4'b0010;
    #1;
    checks++;
    if (req_ready_out !== 4'b0010) begin
      errors++; $display("FAIL single_ready: got %b required 0010", req_ready_out);
    end
    step();
    req_valid_in = 4'b0;
    tx_done_in   = 1'b1;   // done during START must be ignored
    #1;
    checks++;
    if (start_tx_out !== 1'b1 || tx_data_out !== 8'h55 || cfg_reg_out !== 5'b00011 ||
        grant_id_out !== 2'd1 || active_out !== 1'b1 || req_ready_out !== 4'b0) begin
      errors++;
      $display("FAIL single_start: st=%b d=%h cfg=%b gid=%0d act=%b rdy=%b required 1 55 00011 1 1 0000",
               start_tx_out, tx_data_out, cfg_reg_out, grant_id_out, active_out, req_ready_out);
    end
    step();
    tx_done_in = 1'b0;
    #1;
    checks++;
    if (start_tx_out !== 1'b0 || active_out !== 1'b1) begin
      errors++; $display("FAIL single_wait: st=%b act=%b required 0 1", start_tx_out, active_out);
    end
    repeat (3) step();
    tx_done_in = 1'b1;
    step();
    tx_done_in = 1'b0;
    #1;
    checks++;
    if (active_out !== 1'b0 || tx_data_out !== 8'h55 || timeout_err_out !== 1'b0) begin
      errors++; $display("FAIL single_done: act=%b d=%h to=%b required 0 55 0", active_out, tx_data_out, timeout_err_out);
    end
  endtask

  task automatic test_back_to_back();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; step(); rst = 1'b0;
    load_data();
    req_valid_in = 4'b1111;
    #1;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (req_ready_out !== (4'b0001 << exp_g[n])) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b required %b", n, req_ready_out, 4'b0001 << exp_g[n]);
      end
      step();
      checks++;
      if (start_tx_out !== 1'b1 || grant_id_out !== 2'(exp_g[n]) || tx_data_out !== 8'hA0 + 8'(exp_g[n])) begin
        errors++; $display("FAIL rr_start[%0d]: st=%b gid=%0d d=%h required 1 %0d %h",
                           n, start_tx_out, grant_id_out, tx_data_out, exp_g[n], 8'hA0 + 8'(exp_g[n]));
      end
      repeat (10) step();
      tx_done_in = 1'b1;
      checks++;
      if (req_ready_out !== 4'b0 || active_out !== 1'b1) begin
        errors++; $display("FAIL rr_busy[%0d]: rdy=%b act=%b required 0000 1", n, req_ready_out, active_out);
      end
      step();
      tx_done_in = 1'b0;
      if (n == 5) req_valid_in = 4'b0;
      #1;
    end
  endtask

  task automatic test_cts();
    int leak = 0;
    load_data();
    cts_n_in     = 1'b1;
    req_valid_in = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      step();
      if (req_ready_out !== 4'b0 || start_tx_out !== 1'b0) leak++;
    end
    checks++;
    if (leak != 0) begin
      errors++; $display("FAIL cts_block: cycles with grant got %0d required 0", leak);
    end
    tx_busy_in = 1'b1;
    cts_n_in   = 1'b0;
    #1;
    checks++;
    if (req_ready_out !== 4'b0) begin
      errors++; $display("FAIL busy_block: got %b required 0000", req_ready_out);
    end
    tx_busy_in = 1'b0;
    #1;
    checks++;
    if (req_ready_out !== 4'b0100) begin
      errors++; $display("FAIL cts_release: got %b required 0100", req_ready_out);
    end
    step();
    req_valid_in = 4'b0;
    #1;
    checks++;
    if (start_tx_out !== 1'b1 || grant_id_out !== 2'd2 || tx_data_out !== 8'hA2) begin
      errors++; $display("FAIL cts_start: st=%b gid=%0d d=%h required 1 2 a2", start_tx_out, grant_id_out, tx_data_out);
    end
    step();
    tx_done_in = 1'b1;
    step();
    tx_done_in = 1'b0;
  endtask

  task automatic test_timeout();
    int k = 0;
    int leak = 0;
    load_data();
    req_valid_in = 4'b1001;
    #1;
    checks++;
    if (req_ready_out !== 4'b1000) begin
      errors++; $display("FAIL to_ready: got %b required 1000", req_ready_out);
    end
    step();
    req_valid_in = 4'b0001;   // req0 waits through the whole frame
    #1;
    checks++;
    if (start_tx_out !== 1'b1 || grant_id_out !== 2'd3) begin
      errors++; $display("FAIL to_start: st=%b gid=%0d required 1 3", start_tx_out, grant_id_out);
    end
    while (k < 200) begin
      step();
      k++;
      if (timeout_err_out === 1'b1) break;
      if (req_ready_out !== 4'b0) leak++;
    end
    checks++;
    if (k != TMO) begin
      errors++; $display("FAIL to_latency: pulse after %0d cycles required %0d", k, TMO);
    end
    checks++;
    if (leak != 0 || active_out !== 1'b0 || req_ready_out !== 4'b0001) begin
      errors++; $display("FAIL to_return: leak=%0d act=%b rdy=%b required 0 0 0001", leak, active_out, req_ready_out);
    end
    step();
    #1;
    checks++;
    if (timeout_err_out !== 1'b0 || start_tx_out !== 1'b1 || grant_id_out !== 2'd0 || tx_data_out !== 8'hA0) begin
      errors++; $display("FAIL to_next: to=%b st=%b gid=%0d d=%h required 0 1 0 a0",
                         timeout_err_out, start_tx_out, grant_id_out, tx_data_out);
    end
    req_valid_in = 4'b0;
    step();
    tx_done_in = 1'b1;
    step();
    tx_done_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_data();
    req_valid_in = 4'b0010;
    #1;
    checks++;
    if (req_ready_out !== 4'b0010) begin
      errors++; $display("FAIL rm_ready: got %b required 0010", req_ready_out);
    end
    step();
    req_valid_in = 4'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid_in = 4'b1001;
    #1;
    checks++;
    if (tx_data_out !== 8'h00 || cfg_reg_out !== 5'b00011 || grant_id_out !== 2'd0 ||
        active_out !== 1'b0 || start_tx_out !== 1'b0 || timeout_err_out !== 1'b0) begin
      errors++; $display("FAIL rm_values: d=%h cfg=%b gid=%0d act=%b st=%b to=%b required 00 00011 0 0 0 0",
                         tx_data_out, cfg_reg_out, grant_id_out, active_out, start_tx_out, timeout_err_out);
    end
    checks++;
    if (req_ready_out !== 4'b0001) begin
      errors++; $display("FAIL rm_priority: got %b required 0001", req_ready_out);
    end
    step();
    req_valid_in = 4'b0;
    #1;
    checks++;
    if (start_tx_out !== 1'b1 || grant_id_out !== 2'd0 || timeout_err_out !== 1'b0) begin
      errors++; $display("FAIL rm_start: st=%b gid=%0d to=%b required 1 0 0", start_tx_out, grant_id_out, timeout_err_out);
    end
    step();
    tx_done_in = 1'b1;
    step();
    tx_done_in = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid_in = '0;
    req_data_in  = '0;
    req_cfg_in   = '0;
    tx_busy_in   = 1'b0;
    tx_done_in   = 1'b0;
    cts_n_in     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_cts();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
